// File: rtl/if_fetch_unit.sv
// if_fetch_unit: RV32I fetch stage owning the PC, the imem req/gnt/rvalid port and a fetch buffer.
// Optional IF_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises fetch_misalign_o.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          FB_DEPTH  = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        fetch_misalign_o
);

    localparam int AW = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int RW = AW + 2;

`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HALT} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
`endif

    state_t        state;
    logic [31:0]   pc_q;
    logic [31:0]   req_pc_q;
    logic [31:0]   fb_pc    [FB_DEPTH];
    logic [31:0]   fb_instr [FB_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [RW-1:0] reserved;
    logic [31:0]   target;
    logic          busy;
    logic          pend;
    logic          window;
    logic          push;
    logic          pop;
    logic          fire;

    assign busy   = (state == WAIT) || (state == DISCARD);
    assign window = (state == IDLE) || (busy && imem_rvalid_i);
    assign push   = (state == WAIT) && imem_rvalid_i;
    assign valid_o = (count != '0);
    assign pop    = valid_o && !stall_i;
    assign target = redirect_pc_i & 32'hFFFF_FFFC;

    // Slots already spoken for once this edge retires the head.
    assign reserved = RW'(count) + RW'(state == WAIT) - RW'(pop);

    assign imem_req_o = !rst && window && !redirect_i
                      && (reserved < RW'(FB_DEPTH));
    assign imem_addr_o = pc_q;
    assign fire = imem_req_o && imem_gnt_i;

    assign pc_o    = valid_o ? fb_pc[rd_ptr] : 32'h0;
    assign instr_o = valid_o ? fb_instr[rd_ptr] : NOP_INSTR;

`ifdef IF_MISALIGN_TRAP_EN
    logic misalign;
    logic misalign_q;
    logic halt_busy;

    assign misalign = |redirect_pc_i[1:0];
    assign pend = busy || ((state == HALT) && halt_busy);
    assign fetch_misalign_o = misalign_q;
`else
    assign pend = busy;
    assign fetch_misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            for (int i = 0; i < FB_DEPTH; i++) begin
                fb_pc[i]    <= 32'h0;
                fb_instr[i] <= NOP_INSTR;
            end
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
            halt_busy  <= 1'b0;
`endif
        end else if (redirect_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc_q   <= target;
`ifdef IF_MISALIGN_TRAP_EN
            misalign_q <= misalign;
            if (misalign) begin
                state     <= HALT;
                halt_busy <= pend && !imem_rvalid_i;
            end else begin
                state     <= (pend && !imem_rvalid_i) ? DISCARD : IDLE;
                halt_busy <= 1'b0;
            end
`else
            state <= (pend && !imem_rvalid_i) ? DISCARD : IDLE;
`endif
        end else begin
            if (fire) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + 32'd4;
            end
            if (push) begin
                fb_pc[wr_ptr]    <= req_pc_q;
                fb_instr[wr_ptr] <= imem_rdata_i;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (!push && pop) begin
                count <= count - CW'(1);
            end
            unique case (state)
                IDLE: begin
                    if (fire) state <= WAIT;
                end
                WAIT, DISCARD: begin
                    if (imem_rvalid_i) state <= fire ? WAIT : IDLE;
                end
`ifdef IF_MISALIGN_TRAP_EN
                HALT: begin
                    if (imem_rvalid_i) halt_busy <= 1'b0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
